// File: rtl/fc_window_ram_if.sv
// Handshake/bus bundle for fc_window_ram: write port, windowed read port and fill status.
// master drives requests; slave is the buffer itself.
interface fc_window_ram_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int TAPS   = 5
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                     clear;
  logic                     wr_en;
  logic signed [DATA_W-1:0] wr_data;
  logic                     wr_ready;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic                     rd_valid;
  logic [TAPS*DATA_W-1:0]   rd_data;
  logic [CNT_W-1:0]         fill_count;
  logic                     full;

  modport master (
    output clear, wr_en, wr_data, rd_en, rd_addr,
    input  wr_ready, rd_valid, rd_data, fill_count, full
  );

  modport slave (
    input  clear, wr_en, wr_data, rd_en, rd_addr,
    output wr_ready, rd_valid, rd_data, fill_count, full
  );
endinterface

// File: rtl/fc_window_ram.sv
// Sliding-window buffer for the FC stage: sequential writes, TAPS-wide masked window reads.
// Optional macro FC_WINDOW_RAM_WRAP_EN makes window indices wrap modulo DEPTH.
module fc_window_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int TAPS   = 5
) (
  input  logic                CLK,
  input  logic                RST_N,
  fc_window_ram_if.slave      bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int IDX_W  = ADDR_W + 4;

  logic signed [DATA_W-1:0] ram_q [DEPTH];
  logic [CNT_W-1:0]         fill_count_q, fill_count_d;
  logic                     rd_valid_q;
  logic [TAPS*DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [ADDR_W-1:0]        wr_ptr;
  logic                     full;
  logic                     wr_fire;

  // The write pointer always equals the fill count, so it is derived rather than stored.
  assign wr_ptr  = fill_count_q[ADDR_W-1:0];
  assign full    = (fill_count_q == CNT_W'(DEPTH));
  assign wr_fire = bus.wr_en && !full && !bus.clear;

  always_comb begin
    fill_count_d = fill_count_q;
    if (bus.clear)
      fill_count_d = '0;
    else if (wr_fire)
      fill_count_d = fill_count_q + CNT_W'(1);
  end

  // Window assembly from pre-write contents and pre-write fill count.
  always_comb begin
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] fill_ext;
    rd_data_d = '0;
    fill_ext  = IDX_W'(fill_count_q);
    for (int k = 0; k < TAPS; k++) begin
      idx = IDX_W'(bus.rd_addr) + IDX_W'(k);
`ifdef FC_WINDOW_RAM_WRAP_EN
      idx = idx % IDX_W'(DEPTH);
`endif
      // idx < fill_count also implies idx < DEPTH, covering out-of-range addresses.
      if (idx < fill_ext)
        rd_data_d[k*DATA_W +: DATA_W] = ram_q[idx[ADDR_W-1:0]];
    end
  end

  // Storage stage: contents are deliberately never reset.
  always_ff @(posedge CLK) begin
    if (wr_fire)
      ram_q[wr_ptr] <= bus.wr_data;
  end

  // Control and registered read output stage.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fill_count_q <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      fill_count_q <= fill_count_d;
      rd_valid_q   <= bus.rd_en;
      if (bus.rd_en)
        rd_data_q <= rd_data_d;
    end
  end

  assign bus.wr_ready   = !full;
  assign bus.full       = full;
  assign bus.fill_count = fill_count_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
endmodule

// File: tb/tb_fc_window_ram.sv
// Directed self-checking bench for fc_window_ram (default DATA_W=16, DEPTH=32, TAPS=5).
module tb_fc_window_ram;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;
  localparam int TAPS   = 5;

  logic CLK;
  logic RST_N;
  int   n_checks;
  int   n_fail;

  fc_window_ram_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TAPS(TAPS)) bus ();

  fc_window_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TAPS(TAPS)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TAPS*DATA_W-1:0] win(input logic [15:0] e0, input logic [15:0] e1,
                                                 input logic [15:0] e2, input logic [15:0] e3,
                                                 input logic [15:0] e4);
    return {e4, e3, e2, e1, e0};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_write(input logic [15:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_read(input int a);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 5'(a);
    tick();
    bus.rd_en   = 1'b0;
  endtask

  initial begin
    logic [TAPS*DATA_W-1:0] exp_tail;
    logic [TAPS*DATA_W-1:0] exp_last;
    n_checks    = 0;
    n_fail      = 0;
    bus.clear   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    RST_N       = 1'b0;
    #12;
    check("reset_rd_data",  bus.rd_data,    '0);
    check("reset_rd_valid", bus.rd_valid,   0);
    check("reset_fill",     bus.fill_count, 0);
    check("reset_full",     bus.full,       0);
    check("reset_wr_ready", bus.wr_ready,   1);
    RST_N = 1'b1;
    tick();

    // Signed extremes
    do_write(16'h8000);
    do_write(16'hFFFF);
    do_read(0);
    check("signed_window", bus.rd_data, win(16'h8000, 16'hFFFF, 0, 0, 0));
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clear_fill", bus.fill_count, 0);

    // Basic window
    for (int i = 1; i <= 32; i++) do_write(16'(i));
    check("fill_32",     bus.fill_count, 32);
    check("full_32",     bus.full,       1);
    check("wr_ready_32", bus.wr_ready,   0);
    do_read(0);
    check("basic_valid", bus.rd_valid, 1);
    check("basic_data",  bus.rd_data,  win(1, 2, 3, 4, 5));
    tick();
    check("valid_drop",  bus.rd_valid, 0);
    check("data_hold",   bus.rd_data,  win(1, 2, 3, 4, 5));

    // Tail
`ifdef FC_WINDOW_RAM_WRAP_EN
    exp_tail = win(31, 32, 1, 2, 3);
    exp_last = win(32, 1, 2, 3, 4);
`else
    exp_tail = win(31, 32, 0, 0, 0);
    exp_last = win(32, 0, 0, 0, 0);
`endif
    do_read(30);
    check("tail_data", bus.rd_data, exp_tail);
    do_read(31);
    check("last_data", bus.rd_data, exp_last);

    // Overflow drop
    do_write(16'h7FFF);
    check("overflow_fill", bus.fill_count, 32);
    do_read(0);
    check("overflow_ram0", bus.rd_data, win(1, 2, 3, 4, 5));

    // Clear beats write; read in clear cycle sees pre-clear fill
    bus.clear   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'h1234;
    bus.rd_en   = 1'b1;
    bus.rd_addr = '0;
    tick();
    bus.clear = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check("clear_prio_fill",  bus.fill_count, 0);
    check("clear_read_pre",   bus.rd_data,    win(1, 2, 3, 4, 5));
    check("clear_wr_ready",   bus.wr_ready,   1);
    do_read(0);
    check("post_clear_zero",  bus.rd_data,    '0);

    // Partial fill
    do_write(10);
    do_write(20);
    do_write(30);
    do_read(1);
    check("partial_data", bus.rd_data,    win(20, 30, 0, 0, 0));
    check("partial_fill", bus.fill_count, 3);
    do_read(0);
    check("write_at_zero", bus.rd_data,   win(10, 20, 30, 0, 0));

    // Read/write collision
    do_write(40);
    bus.wr_en   = 1'b1;
    bus.wr_data = 50;
    bus.rd_en   = 1'b1;
    bus.rd_addr = 5'd3;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check("collide_rbw",  bus.rd_data,    win(40, 0, 0, 0, 0));
    check("collide_fill", bus.fill_count, 5);
    do_read(3);
    check("collide_next", bus.rd_data,    win(40, 50, 0, 0, 0));

    // Back-to-back reads then async reset between edges
    bus.rd_en   = 1'b1;
    bus.rd_addr = '0;
    tick();
    check("b2b_valid0", bus.rd_valid, 1);
    bus.rd_addr = 5'd1;
    tick();
    check("b2b_valid1", bus.rd_valid, 1);
    check("b2b_data1",  bus.rd_data,  win(20, 30, 40, 50, 0));
    #2;
    RST_N = 1'b0;
    #1;
    check("async_valid", bus.rd_valid,   0);
    check("async_data",  bus.rd_data,    '0);
    check("async_fill",  bus.fill_count, 0);
    bus.rd_en = 1'b0;
    #3;
    RST_N = 1'b1;
    tick();
    check("after_reset_valid", bus.rd_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
